// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory and its UART MMIO window.
// Register offsets, status bit positions and the status word packer.
package dmem_pkg;

  localparam logic [1:0] TX_DATA_OFS = 2'd0;
  localparam logic [1:0] RX_DATA_OFS = 2'd1;
  localparam logic [1:0] CTRL_OFS    = 2'd2;
  localparam logic [1:0] STAT_OFS    = 2'd3;

  localparam int STAT_TXRDY = 0;
  localparam int STAT_RXVAL = 1;
  localparam int STAT_OVR   = 8;

  localparam int CTRL_RXIE  = 0;
  localparam int CH_STRIDE  = 16;

  function automatic logic [31:0] status_word(input logic txrdy,
                                              input logic rxval,
                                              input logic ovr);
    logic [31:0] s;
    s             = '0;
    s[STAT_TXRDY] = txrdy;
    s[STAT_RXVAL] = rxval;
    s[STAT_OVR]   = ovr;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_mmio_regs.sv
// Per-channel UART register block: control, latched TX data, sticky overrun,
// push/pop strobes and the RX interrupt (built only with DMEM_RX_IRQ_EN).
module uart_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [1:0]  ofs_i,
  input  logic [31:0] wdata_i,
  input  logic        tx_ready_i,
  input  logic        rx_valid_i,
  output logic [31:0] tx_data_o,
  output logic [31:0] ctrl_o,
  output logic        tx_wr_o,
  output logic        rx_rd_o,
  output logic        ovr_o,
  output logic        irq_o
);

  logic [31:0] tx_data_q, tx_data_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        tx_wr_q, tx_wr_d;
  logic        rx_rd_q, rx_rd_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;

  logic tx_push, ovr_set, ovr_clr;

  always_comb begin
    tx_push   = wr_i && (ofs_i == TX_DATA_OFS);
    ovr_set   = tx_push && !tx_ready_i;
    ovr_clr   = wr_i && (ofs_i == STAT_OFS) && wdata_i[STAT_OVR];

    tx_wr_d   = tx_push && tx_ready_i;
    tx_data_d = tx_wr_d ? wdata_i : tx_data_q;
    ctrl_d    = (wr_i && (ofs_i == CTRL_OFS)) ? wdata_i : ctrl_q;
    rx_rd_d   = rd_i && (ofs_i == RX_DATA_OFS) && rx_valid_i;

    // a new overrun outranks a clear arriving in the same cycle
    ovr_d = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;

`ifdef DMEM_RX_IRQ_EN
    irq_d = ctrl_q[CTRL_RXIE] & rx_valid_i;
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_data_q <= '0;
      ctrl_q    <= '0;
      tx_wr_q   <= 1'b0;
      rx_rd_q   <= 1'b0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      ctrl_q    <= ctrl_d;
      tx_wr_q   <= tx_wr_d;
      rx_rd_q   <= rx_rd_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign ctrl_o    = ctrl_q;
  assign tx_wr_o   = tx_wr_q;
  assign rx_rd_o   = rx_rd_q;
  assign ovr_o     = ovr_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/data_mem_mmio.sv
// LSU-facing data memory: byte-enable word RAM plus a decoded window of UART
// register blocks. RX interrupt generation is enabled by DMEM_RX_IRQ_EN.
module data_mem_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          NUM_CH    = 1,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  input  logic [NUM_CH-1:0]     tx_ready_i,
  output logic [NUM_CH-1:0]     tx_wr_o,
  output logic [32*NUM_CH-1:0]  tx_data_o,
  input  logic [NUM_CH-1:0]     rx_valid_i,
  input  logic [32*NUM_CH-1:0]  rx_data_i,
  output logic [NUM_CH-1:0]     rx_rd_o,
  output logic [32*NUM_CH-1:0]  uart_control_o,
  output logic [NUM_CH-1:0]     irq_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] MMIO_END = MMIO_BASE + 32'(CH_STRIDE * NUM_CH);

  logic [31:0] mem_q [DEPTH];

  logic          is_mmio;
  logic [1:0]    ch_idx;
  logic [1:0]    ofs;
  logic [AW-1:0] widx;

  logic [31:0] ctrl_w [NUM_CH];
  logic [NUM_CH-1:0] ovr_w;

  logic [31:0] rd_word;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  assign is_mmio = (addr_i >= MMIO_BASE) && (addr_i < MMIO_END);
  assign ch_idx  = 2'((addr_i - MMIO_BASE) >> 4);
  assign ofs     = addr_i[3:2];
  // out-of-range RAM addresses silently wrap onto the array
  assign widx    = addr_i[AW+1:2];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic ch_sel;
    assign ch_sel = is_mmio && (ch_idx == 2'(n));

    uart_mmio_regs u_regs (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_i       (wr_en_i && ch_sel && (be_i == 4'hF)),
      .rd_i       (rd_en_i && ch_sel),
      .ofs_i      (ofs),
      .wdata_i    (wdata_i),
      .tx_ready_i (tx_ready_i[n]),
      .rx_valid_i (rx_valid_i[n]),
      .tx_data_o  (tx_data_o[32*n +: 32]),
      .ctrl_o     (ctrl_w[n]),
      .tx_wr_o    (tx_wr_o[n]),
      .rx_rd_o    (rx_rd_o[n]),
      .ovr_o      (ovr_w[n]),
      .irq_o      (irq_o[n])
    );

    assign uart_control_o[32*n +: 32] = ctrl_w[n];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (!is_mmio) begin
      rd_word = mem_q[widx];
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == 2'(n)) begin
          case (ofs)
            RX_DATA_OFS: rd_word = rx_valid_i[n] ? rx_data_i[32*n +: 32] : '0;
            CTRL_OFS:    rd_word = ctrl_w[n];
            STAT_OFS:    rd_word = status_word(tx_ready_i[n], rx_valid_i[n], ovr_w[n]);
            default:     rd_word = '0;
          endcase
        end
      end
    end
  end

  // registering the pre-write word gives read-before-write on collisions
  always_comb begin
    rvalid_d = rd_en_i;
    rdata_d  = rd_en_i ? rd_word : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio (2 channels, 64-word RAM) with a
// transaction-level reference model checked every cycle.
module tb_data_mem_mmio;

  localparam int          DEPTH = 64;
  localparam int          NCH   = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DMEM_RX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, rd_en;
  logic [3:0]        be;
  logic [31:0]       addr, wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic [NCH-1:0]    tx_ready, tx_wr, rx_valid, rx_rd, irq;
  logic [32*NCH-1:0] tx_data, rx_data, uart_control;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_mmio #(.DEPTH(DEPTH), .NUM_CH(NCH), .MMIO_BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .tx_ready_i(tx_ready), .tx_wr_o(tx_wr), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_rd_o(rx_rd),
    .uart_control_o(uart_control), .irq_o(irq)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] ctrl_m [NCH];
  logic [31:0] txd_m [NCH];
  bit          ovr_m [NCH];
  logic [31:0] e_rdata;
  bit          e_rdata_ok;
  logic        e_rvalid;
  logic [NCH-1:0] e_tx_wr, e_rx_rd, e_irq;
  bit          started = 0;

  always @(posedge clk) begin
    bit in_win;
    int ch, rg, idx;
    started = 1;
    in_win = (addr >= BASE) && (addr < BASE + 32'(16 * NCH));
    ch  = int'((addr - BASE) / 16);
    rg  = int'((addr % 16) / 4);
    idx = int'((addr / 4) % DEPTH);
    if (rst) begin
      e_rdata = 0; e_rdata_ok = 1; e_rvalid = 0;
      e_tx_wr = 0; e_rx_rd = 0; e_irq = 0;
      for (int n = 0; n < NCH; n++) begin
        ctrl_m[n] = 0; txd_m[n] = 0; ovr_m[n] = 0;
      end
    end else begin
      for (int n = 0; n < NCH; n++)
        e_irq[n] = IRQ_EN && ctrl_m[n][0] && rx_valid[n];
      e_rvalid = rd_en;
      e_tx_wr  = 0;
      e_rx_rd  = 0;
      if (rd_en) begin
        e_rdata_ok = 1;
        if (!in_win) begin
          e_rdata = mem_m[idx];
          e_rdata_ok = known_m[idx];
        end else begin
          case (rg)
            0: e_rdata = 0;
            1: begin
              e_rdata = rx_valid[ch] ? rx_data[ch*32 +: 32] : 32'h0;
              e_rx_rd[ch] = rx_valid[ch];
            end
            2: e_rdata = ctrl_m[ch];
            default: e_rdata = {23'h0, ovr_m[ch], 6'h0, rx_valid[ch], tx_ready[ch]};
          endcase
        end
      end
      if (wr_en) begin
        if (!in_win) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
          if (be == 4'hF) known_m[idx] = 1;
        end else if (be == 4'hF) begin
          case (rg)
            0: if (tx_ready[ch]) begin txd_m[ch] = wdata; e_tx_wr[ch] = 1; end
               else ovr_m[ch] = 1;
            2: ctrl_m[ch] = wdata;
            3: if (wdata[8]) ovr_m[ch] = 0;
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rvalid", 64'(rvalid), 64'(e_rvalid));
      if (e_rvalid && e_rdata_ok) chk("rdata", 64'(rdata), 64'(e_rdata));
      chk("tx_wr", 64'(tx_wr), 64'(e_tx_wr));
      chk("rx_rd", 64'(rx_rd), 64'(e_rx_rd));
      chk("tx_data", tx_data, {txd_m[1], txd_m[0]});
      chk("uart_control", uart_control, {ctrl_m[1], ctrl_m[0]});
      chk("irq", 64'(irq), 64'(e_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic w, input logic r, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; be = b; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 0; rd_en = 0; be = 0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    op(1'b1, 1'b0, b, a, d);
  endtask

  task automatic ld(input logic [31:0] a);
    op(1'b0, 1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; be = 0; addr = 0; wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = {32'h0000_0066, 32'h0000_0055};
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_tx_data", tx_data, 64'h0);
    chk("rst_ctrl", uart_control, 64'h0);
    rst = 0;

    // RAM byte lanes, wrap, be=0 and read-before-write
    st(32'h10, 32'hDEAD_BEEF, 4'hF);
    st(32'h10, 32'h0000_AA00, 4'b0010);
    ld(32'h10);
    chk("ld_be", 64'(rdata), 64'hDEAD_AAEF);
    chk("ld_rvalid", 64'(rvalid), 64'h1);
    idle();
    chk("rvalid_pulse", 64'(rvalid), 64'h0);
    ld(32'((DEPTH + 4) * 4));
    chk("ld_wrap", 64'(rdata), 64'hDEAD_AAEF);
    st(32'h114, 32'h1234_5678, 4'hF);
    st(32'h14, 32'hFFFF_FFFF, 4'h0);
    ld(32'h14);
    chk("st_wrap_be0", 64'(rdata), 64'h1234_5678);
    op(1'b1, 1'b1, 4'hF, 32'h14, 32'hCAFE_F00D);
    chk("rbw", 64'(rdata), 64'h1234_5678);
    ld(32'h14);
    chk("rbw_new", 64'(rdata), 64'hCAFE_F00D);
    st(32'h1020, 32'hAABB_CCDD, 4'hF);
    ld(32'h20);
    chk("past_window", 64'(rdata), 64'hAABB_CCDD);

    // TX push, overrun, W1C
    tx_ready = 2'b11;
    st(BASE, 32'h41, 4'hF);
    chk("tx_wr0", 64'(tx_wr), 64'h1);
    chk("tx_data0", 64'(tx_data[31:0]), 64'h41);
    idle();
    chk("tx_wr_pulse", 64'(tx_wr), 64'h0);
    tx_ready = 2'b10;
    st(BASE, 32'h42, 4'hF);
    chk("tx_drop", 64'(tx_wr), 64'h0);
    ld(BASE + 32'hC);
    chk("stat_ovr", 64'(rdata), 64'h100);
    st(BASE + 32'hC, 32'h100, 4'hF);
    ld(BASE + 32'hC);
    chk("stat_clr", 64'(rdata), 64'h0);
    tx_ready = 2'b11;
    st(BASE, 32'h61, 4'hF);
    st(BASE, 32'h62, 4'hF);
    chk("b2b_data", 64'(tx_data[31:0]), 64'h62);
    st(BASE + 32'h10, 32'h77, 4'hF);
    chk("tx_wr1", 64'(tx_wr), 64'h2);
    tx_ready = 2'b01;
    st(BASE, 32'h63, 4'hF);
    tx_ready = 2'b00;
    st(BASE, 32'h64, 4'hF);
    st(BASE, 32'h65, 4'h1);
    ld(BASE);
    chk("tx_rd_zero", 64'(rdata), 64'h0);

    // RX pop
    rx_valid = 2'b01;
    ld(BASE + 32'h4);
    chk("rx_data", 64'(rdata), 64'h55);
    chk("rx_rd", 64'(rx_rd), 64'h1);
    rx_valid = 2'b00;
    ld(BASE + 32'h4);
    chk("rx_empty", 64'(rdata), 64'h0);
    chk("rx_nopop", 64'(rx_rd), 64'h0);

    // control on channel 1, partial write ignored, irq
    tx_ready = 2'b10;
    st(BASE + 32'h18, 32'h1, 4'h3);
    ld(BASE + 32'h18);
    chk("ctrl_partial", 64'(rdata), 64'h0);
    st(BASE + 32'h18, 32'h1, 4'hF);
    chk("ctrl_ch1", uart_control, 64'h0000_0001_0000_0000);
    rx_valid = 2'b10;
    idle();
    chk("irq_on", 64'(irq), IRQ_EN ? 64'h2 : 64'h0);
    ld(BASE + 32'h1C);
    chk("stat_ch1", 64'(rdata), 64'h3);
    rx_valid = 2'b00;
    idle();
    chk("irq_off", 64'(irq), 64'h0);

    // reset mid-operation
    tx_ready = 2'b11;
    st(BASE, 32'h99, 4'hF);
    chk("pre_rst_wr", 64'(tx_wr), 64'h1);
    rst = 1;
    idle();
    chk("rst_tx_wr", 64'(tx_wr), 64'h0);
    chk("rst_tx_data2", tx_data, 64'h0);
    op(1'b1, 1'b1, 4'hF, BASE, 32'h5A);
    chk("rst_wr_ign", 64'(tx_wr), 64'h0);
    chk("rst_rd_ign", 64'(rvalid), 64'h0);
    rst = 0;
    idle();
    chk("post_rst", 64'(tx_wr), 64'h0);
    ld(32'h14);
    chk("ram_kept", 64'(rdata), 64'hCAFE_F00D);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
